// File: rtl/f_result_queue.sv
// Purpose : capture stage for the mul/add/sub datapath; flags truncation overflow,
//           buffers {ovf, f} in a DEPTH-entry FIFO, keeps saturating statistics.
// Latency : push-to-head 1 cycle when empty (no bypass); statistics visible 1 cycle after push.
// Backpr. : in_ready = (count != DEPTH) from registered state only; a full queue refuses
//           a push even when a pop happens in the same cycle.
//
// Ports:
//   Clk, Rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    producer handshake; f_in (4b truncated), f_full_in (9b untruncated)
//   out_valid/out_ready  consumer handshake; out_data (4b), out_ovf (head overflow flag)
//   count                occupied entries (PTR_W+1 bits)
//   clr_stats            synchronous clear of acc_sum / ovf_count (wins over a same-cycle push)
//   acc_sum, ovf_count   saturating 8-bit sum of accepted f_in / count of overflowed pushes
module f_result_queue #(
    parameter int DEPTH = 4,    // power of two, 2..16
    parameter int PTR_W = 2     // log2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    input  logic [3:0]       f_in,
    input  logic [8:0]       f_full_in,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic             out_ovf,
    output logic [PTR_W:0]   count,
    input  logic             clr_stats,
    output logic [7:0]       acc_sum,
    output logic [7:0]       ovf_count
);

    typedef struct packed {
        logic       ovf;
        logic [3:0] dat;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       acc_sum_q, acc_sum_d;
    logic [7:0]       ovf_count_q, ovf_count_d;

    logic             ovf;
    logic             push;
    logic             pop;
    logic [8:0]       sum_wide;

    // Any set bit above the low nibble means the result did not fit in 4 bits;
    // this also catches negative (wrapped) subtract results.
    assign ovf = |f_full_in[8:4];

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data  = mem_q[rd_ptr_q].dat;
    assign out_ovf   = mem_q[rd_ptr_q].ovf;
    assign count     = count_q;
    assign acc_sum   = acc_sum_q;
    assign ovf_count = ovf_count_q;

    // Sum is formed one bit wider so a carry out can be detected and clamped.
    assign sum_wide = {1'b0, acc_sum_q} + {5'b0_0000, f_in};

    // Pointers are exactly PTR_W bits wide and DEPTH = 2**PTR_W, so the natural
    // binary rollover is the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        acc_sum_d   = acc_sum_q;
        ovf_count_d = ovf_count_q;
        if (clr_stats) begin
            acc_sum_d   = '0;
            ovf_count_d = '0;
        end else if (push) begin
            acc_sum_d = sum_wide[8] ? 8'hFF : sum_wide[7:0];
            if (ovf && (ovf_count_q != 8'hFF)) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_sum_q   <= '0;
            ovf_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_sum_q   <= acc_sum_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Storage needs no reset: an entry is only observable once count covers it,
    // and reset clears count.
    always_ff @(posedge Clk) begin
        if (push && !Rst) begin
            mem_q[wr_ptr_q] <= '{ovf: ovf, dat: f_in};
        end
    end

endmodule

// File: tb/tb_f_result_queue.sv
// Purpose : directed self-checking bench for f_result_queue (DEPTH=4).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpr. : exercises full refusal, push+pop overlap and drain.
module tb_f_result_queue;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       in_valid;
    logic [3:0] f_in;
    logic [8:0] f_full_in;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ovf;
    logic [2:0] count;
    logic       clr_stats;
    logic [7:0] acc_sum;
    logic [7:0] ovf_count;

    int n_checks = 0;
    int n_errors = 0;

    f_result_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .f_in      (f_in),
        .f_full_in (f_full_in),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .count     (count),
        .clr_stats (clr_stats),
        .acc_sum   (acc_sum),
        .ovf_count (ovf_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst       = 1'b1;
        in_valid  = 1'b1;
        f_in      = 4'd5;
        f_full_in = 9'h005;
        out_ready = 1'b0;
        clr_stats = 1'b0;

        // Reset held 2 cycles with in_valid high: nothing may be captured.
        step();
        step();
        Rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_acc_sum", int'(acc_sum), 0);
        check("rst_ovf_count", int'(ovf_count), 0);

        // Single capture: 15x15 = 225 = 9'h0E1, truncated to 1 -> overflow.
        in_valid  = 1'b1;
        f_in      = 4'h1;
        f_full_in = 9'h0E1;
        #1;
        check("nobypass_out_valid", int'(out_valid), 0);
        step();
        in_valid = 1'b0;
        check("cap_out_valid", int'(out_valid), 1);
        check("cap_out_data", int'(out_data), 1);
        check("cap_out_ovf", int'(out_ovf), 1);
        check("cap_acc_sum", int'(acc_sum), 1);
        check("cap_ovf_count", int'(ovf_count), 1);

        // Second capture while popping the first.
        in_valid  = 1'b1;
        f_in      = 4'd3;
        f_full_in = 9'h003;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("cap2_count", int'(count), 1);
        check("cap2_out_data", int'(out_data), 3);
        check("cap2_out_ovf", int'(out_ovf), 0);
        check("cap2_acc_sum", int'(acc_sum), 4);
        check("cap2_ovf_count", int'(ovf_count), 1);
        step();
        out_ready = 1'b0;
        check("cap2_drained", int'(out_valid), 0);

        // Clear stats with no push.
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("clr_acc_sum", int'(acc_sum), 0);
        check("clr_ovf_count", int'(ovf_count), 0);

        // Fill 4,5,6,7.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            f_in      = 4'(4 + i);
            f_full_in = 9'(4 + i);
            step();
        end
        check("fill_count", int'(count), 4);
        check("fill_in_ready", int'(in_ready), 0);
        check("fill_acc_sum", int'(acc_sum), 22);

        // Fifth push while full is refused.
        f_in      = 4'd8;
        f_full_in = 9'd8;
        step();
        check("full_refuse_count", int'(count), 4);
        check("full_refuse_acc_sum", int'(acc_sum), 22);

        // Drain; the first drain cycle still offers 8, which must be refused.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i == 0);
            check($sformatf("drain_head%0d", i), int'(out_data), 4 + i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_out_valid", int'(out_valid), 0);
        check("drain_count", int'(count), 0);
        check("drain_acc_sum", int'(acc_sum), 22);

        // Wrap and overlap: prefill 0,1 then push+pop 10 cycles.
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            f_in      = 4'(i);
            f_full_in = 9'(i);
            step();
        end
        check("ovl_pre_count", int'(count), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            f_in      = 4'(i + 2);
            f_full_in = 9'(i + 2);
            check($sformatf("ovl_head%0d", i), int'(out_data), i);
            step();
            check($sformatf("ovl_count%0d", i), int'(count), 2);
        end
        in_valid = 1'b0;
        check("ovl_tail_a", int'(out_data), 10);
        step();
        check("ovl_tail_b", int'(out_data), 11);
        step();
        out_ready = 1'b0;
        check("ovl_empty", int'(out_valid), 0);

        // Saturation: twenty pushes of 15 with 9'h1FF (negative subtract).
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            in_valid  = 1'b1;
            f_in      = 4'd15;
            f_full_in = 9'h1FF;
            out_ready = (k > 1);
            step();
            check($sformatf("sat_acc%0d", k), int'(acc_sum), (15 * k > 255) ? 255 : 15 * k);
        end
        check("sat_ovf_count", int'(ovf_count), 20);
        check("sat_count", int'(count), 1);
        check("sat_head_ovf", int'(out_ovf), 1);
        check("sat_head_data", int'(out_data), 15);

        // Clear together with a push: clear wins, FIFO still takes the entry.
        out_ready = 1'b0;
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        check("clrpush_acc_sum", int'(acc_sum), 0);
        check("clrpush_ovf_count", int'(ovf_count), 0);
        check("clrpush_count", int'(count), 2);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        check("clrpush_drained", int'(count), 0);

        // Reset mid-operation with three entries held.
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            f_in      = 4'(i + 1);
            f_full_in = 9'(i + 1);
            step();
        end
        in_valid = 1'b0;
        check("mid_pre_count", int'(count), 3);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        in_valid  = 1'b1;
        f_in      = 4'd9;
        f_full_in = 9'd9;
        step();
        in_valid = 1'b0;
        check("mid_push_out_valid", int'(out_valid), 1);
        check("mid_push_out_data", int'(out_data), 9);
        check("mid_push_count", int'(count), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/f_result_queue.md
# f_result_queue

Downstream capture stage for the multiply/add/subtract datapath. It samples the 4-bit truncated result `f` together with its 9-bit untruncated check value `f_untruncatedCheck`, and flags truncation overflow on each sample. Flagged results are buffered in a small FIFO for a ready/valid consumer. Running statistics are kept alongside: a saturating sum of accepted results and a count of overflowed results.

## Interface
- `DEPTH`, default 4: number of FIFO entries; must be a power of two, 2..16.
- `PTR_W`, default 2: pointer width, equal to log2(DEPTH).
- `Clk`  input  1  rising-edge clock.
- `Rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  `f_in`/`f_full_in` hold a result to capture.
- `f_in`  input  4  truncated result `f`.
- `f_full_in`  input  9  untruncated result `f_untruncatedCheck`.
- `in_ready`  output  1  the queue can accept a result this cycle.
- `out_ready`  input  1  the consumer takes the head entry this cycle.
- `out_valid`  output  1  the head entry is valid.
- `out_data`  output  4  head entry result.
- `out_ovf`  output  1  head entry overflow flag.
- `count`  output  PTR_W+1  number of occupied entries.
- `clr_stats`  input  1  synchronous clear of `acc_sum` and `ovf_count`.
- `acc_sum`  output  8  saturating sum of accepted `f_in`.
- `ovf_count`  output  8  saturating count of accepted entries with overflow set.

## Operation
- Overflow flag: ovf = OR of `f_full_in[8:4]`. It is set whenever the untruncated value does not fit in 4 bits, including a wrapped or negative subtract result.
- Push: `push = in_valid & in_ready`. On push, the entry {ovf, `f_in`} is written at the write pointer and the write pointer increments modulo DEPTH.
- Pop: `pop = out_valid & out_ready`. On pop, the read pointer increments modulo DEPTH.
- `in_ready = (count != DEPTH)`. It is combinational from registered state only and never depends on `out_ready`.
- When full, a push is refused even if a pop happens in the same cycle.
- `out_valid = (count != 0)`. `out_data`/`out_ovf` come from the entry at the read pointer; their value is don't-care when `out_valid` = 0.
- Count update:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged. Legal when 0 < count < DEPTH.
  - neither: count unchanged.
- No bypass: pushing into an empty queue makes `out_valid` = 1 on the next cycle, not in the same cycle.
- Statistics, updated on push only:
  - `acc_sum` ← min(`acc_sum` + `f_in`, 255), computed in 9 bits and then clamped.
  - `ovf_count` ← min(`ovf_count` + ovf, 255).
- `clr_stats` = 1 zeroes both statistics next cycle. If a push occurs in the same cycle, the clear wins and the pushed value is not counted. FIFO contents are unaffected by `clr_stats`.
- FIFO state set: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Transitions follow the count update rules above; the state is implied by `count` and is not stored separately.

## Timing
- Every register updates on the rising edge of `Clk`.
- Reset values (state after a cycle with `Rst` = 1): pointers 0, `count` 0, `acc_sum` 0, `ovf_count` 0. As a result, `out_valid` = 0 and `in_ready` = 1.
- `Rst` has priority over push, pop and `clr_stats`. Reset during operation discards all stored entries within one cycle.
- Latency from push to head visibility: 1 cycle when empty. Otherwise the entry becomes visible after the entries ahead of it are popped.
- Throughput: one push and one pop per cycle sustained in PARTIAL.
- Statistics are visible 1 cycle after the push that updates them.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0 with no bubble or reordering.

## Test plan
- **Reset:** hold `Rst` = 1 for 2 cycles with `in_valid` = 1 → `count` = 0, `out_valid` = 0, `in_ready` = 1, `acc_sum` = 0, `ovf_count` = 0.
- **Single capture:** push `f_in` = 4'h1, `f_full_in` = 9'h0E1 (the 15×15 case) → next cycle `out_valid` = 1, `out_data` = 1, `out_ovf` = 1, `acc_sum` = 1, `ovf_count` = 1. Then push `f_full_in` = 9'h003, `f_in` = 3 with `out_ready` = 1 → order preserved and the second entry has `out_ovf` = 0.
- **Fill:** with `out_ready` = 0, push 4, 5, 6, 7 → `count` = 4, `in_ready` = 0. A fifth push of 8 with `in_valid` = 1 is ignored and `acc_sum` stays 22. Drain → 4, 5, 6, 7 in order, then `out_valid` = 0.
- **Wrap and overlap:** hold `count` = 2 and run push and pop every cycle for 10 cycles with values 0..9 → `count` stays 2, the popped sequence is exact, and the pointers wrap twice.
- **Saturation and clear:** push `f_in` = 15 with `f_full_in` = 9'h1FF twenty times while draining → `acc_sum` = 255 (saturates after push 17), `ovf_count` = 20. Then `clr_stats` = 1 together with a push → both statistics read 0.
- **Reset mid-operation:** with `count` = 3, assert `Rst` for 1 cycle → next cycle `count` = 0, `out_valid` = 0. A following push of 9 appears at the head one cycle later.
